gem_cluster_injector: RTL and testbench

GEM_CLUSTER_INJECTOR -- requirements
Module: gem_cluster_injector

---
 rtl/gem_cluster_injector.sv | 211 +++++++++++++++++++++
 tb/tb_gem_cluster_injector.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gem_cluster_injector.sv
// GEM cluster injector: a MXFRAMES x MXCLUSTERS pattern buffer of cluster words,
// replayed one BX frame per clock onto registered copad-format cluster outputs.
module gem_cluster_injector #(
    parameter int MXCLUSTERS = 8,
    parameter int MXCLSTB    = 14,
    parameter int MXFRAMES   = 16,
    parameter int MXFRAMEB   = 4
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_wr_en,
    input  logic [MXFRAMEB-1:0] i_wr_frame,
    input  logic [2:0]          i_wr_slot,
    input  logic [MXCLSTB-1:0]  i_wr_data,
    input  logic                i_clear,
    input  logic                i_inj_start,
    input  logic [MXFRAMEB-1:0] i_inj_last,
    input  logic                i_inj_repeat,
    input  logic                i_inj_stop,
    output logic [MXCLSTB-1:0]  o_cluster0,
    output logic [MXCLSTB-1:0]  o_cluster1,
    output logic [MXCLSTB-1:0]  o_cluster2,
    output logic [MXCLSTB-1:0]  o_cluster3,
    output logic [MXCLSTB-1:0]  o_cluster4,
    output logic [MXCLSTB-1:0]  o_cluster5,
    output logic [MXCLSTB-1:0]  o_cluster6,
    output logic [MXCLSTB-1:0]  o_cluster7,
    output logic                o_inj_valid,
    output logic [MXFRAMEB-1:0] o_frame_idx,
    output logic                o_busy,
    output logic                o_done,
    output logic [7:0]          o_pass_cnt
);

    // cnt=0, adr=0x7FF: adr[10:9]=11 marks the cluster invalid downstream
    localparam logic [MXCLSTB-1:0]  BLANK      = MXCLSTB'(14'h07FF);
    localparam logic [MXFRAMEB-1:0] LAST_FRAME = MXFRAMEB'(MXFRAMES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_PLAY  = 2'd2
    } state_t;

    state_t              r_state;
    logic [MXFRAMEB-1:0] r_clr_idx;
    logic [MXFRAMEB-1:0] r_frame_idx;
    logic [MXFRAMEB-1:0] r_last;
    logic                r_repeat;
    logic                r_inj_valid;
    logic                r_busy;
    logic                r_done;
    logic [7:0]          r_pass_cnt;

    state_t              w_state_next;
    logic [MXFRAMEB-1:0] w_clr_idx_next;
    logic [MXFRAMEB-1:0] w_frame_next;
    logic [MXFRAMEB-1:0] w_last_next;
    logic                w_repeat_next;
    logic                w_valid_next;
    logic                w_done_next;
    logic [7:0]          w_pass_next;
    logic                w_pass_inc;
    logic                w_pass_end;
    logic                w_clear_row;
    logic                w_wr_word;
    logic [MXFRAMEB-1:0] w_waddr;
    logic [MXCLSTB-1:0]  w_wdata;
    logic [MXCLSTB-1:0]  w_cluster [MXCLUSTERS];

    assign w_pass_end = (r_frame_idx == r_last);

    always_comb begin
        w_state_next   = r_state;
        w_clr_idx_next = r_clr_idx;
        w_frame_next   = r_frame_idx;
        w_last_next    = r_last;
        w_repeat_next  = r_repeat;
        w_valid_next   = r_inj_valid;
        w_done_next    = 1'b0;
        w_pass_inc     = 1'b0;
        w_pass_next    = r_pass_cnt;
        w_clear_row    = 1'b0;
        w_wr_word      = 1'b0;
        w_waddr        = r_clr_idx;
        w_wdata        = BLANK;

        case (r_state)
            S_IDLE: begin
                w_valid_next = 1'b0;
                w_frame_next = '0;
                if (i_clear) begin
                    w_state_next   = S_CLEAR;
                    w_clr_idx_next = '0;
                end else if (i_inj_start) begin
                    w_state_next  = S_PLAY;
                    w_last_next   = i_inj_last;
                    w_repeat_next = i_inj_repeat;
                    w_valid_next  = 1'b1;
                end else if (i_wr_en) begin
                    w_wr_word = 1'b1;
                    w_waddr   = i_wr_frame;
                    w_wdata   = i_wr_data;
                end
            end

            S_CLEAR: begin
                w_clear_row = 1'b1;
                if (r_clr_idx == LAST_FRAME) begin
                    w_state_next   = S_IDLE;
                    w_clr_idx_next = '0;
                end else begin
                    w_clr_idx_next = r_clr_idx + MXFRAMEB'(1);
                end
            end

            S_PLAY: begin
                // A stop on the last frame of a pass still completes that pass
                if (i_inj_stop || (w_pass_end && !r_repeat)) begin
                    w_state_next = S_IDLE;
                    w_valid_next = 1'b0;
                    w_frame_next = '0;
                    w_done_next  = 1'b1;
                    w_pass_inc   = w_pass_end;
                end else if (w_pass_end) begin
                    w_frame_next = '0;
                    w_pass_inc   = 1'b1;
                end else begin
                    w_frame_next = r_frame_idx + MXFRAMEB'(1);
                end
            end

            default: begin
                w_state_next = S_CLEAR;
                w_valid_next = 1'b0;
                w_frame_next = '0;
            end
        endcase

        if (w_pass_inc && (r_pass_cnt != 8'hFF)) begin
            w_pass_next = r_pass_cnt + 8'd1;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state     <= S_CLEAR;
            r_clr_idx   <= '0;
            r_frame_idx <= '0;
            r_last      <= '0;
            r_repeat    <= 1'b0;
            r_inj_valid <= 1'b0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_pass_cnt  <= 8'd0;
        end else begin
            r_state     <= w_state_next;
            r_clr_idx   <= w_clr_idx_next;
            r_frame_idx <= w_frame_next;
            r_last      <= w_last_next;
            r_repeat    <= w_repeat_next;
            r_inj_valid <= w_valid_next;
            r_busy      <= (w_state_next != S_IDLE);
            r_done      <= w_done_next;
            r_pass_cnt  <= w_pass_next;
        end
    end

    // One RAM column per slot so CLEAR can blank a whole frame in a single clock
    for (genvar gi = 0; gi < MXCLUSTERS; gi++) begin : g_slot
        logic [MXCLSTB-1:0] r_mem [MXFRAMES];
        logic [MXCLSTB-1:0] r_cluster;
        logic               w_we;

        assign w_we = !i_reset &&
                      (w_clear_row || (w_wr_word && (i_wr_slot == 3'(gi))));

        always_ff @(posedge i_clock) begin
            if (w_we) begin
                r_mem[w_waddr] <= w_wdata;
            end
        end

        always_ff @(posedge i_clock) begin
            if (i_reset) begin
                r_cluster <= BLANK;
            end else if (w_valid_next) begin
                r_cluster <= r_mem[w_frame_next];
            end else begin
                r_cluster <= BLANK;
            end
        end

        assign w_cluster[gi] = r_cluster;
    end

    assign o_cluster0  = w_cluster[0];
    assign o_cluster1  = w_cluster[1];
    assign o_cluster2  = w_cluster[2];
    assign o_cluster3  = w_cluster[3];
    assign o_cluster4  = w_cluster[4];
    assign o_cluster5  = w_cluster[5];
    assign o_cluster6  = w_cluster[6];
    assign o_cluster7  = w_cluster[7];
    assign o_inj_valid = r_inj_valid;
    assign o_frame_idx = r_frame_idx;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_pass_cnt  = r_pass_cnt;

endmodule

// File: tb/tb_gem_cluster_injector.sv
// Bench for gem_cluster_injector: directed vector table, hand-written corner
// sequences and randomized write/play/clear traffic against a frame-level model.
module tb_gem_cluster_injector;

    localparam logic [13:0] BLANK = 14'h07FF;

    logic        clk = 1'b0;
    logic        reset, wr_en, clear, inj_start, inj_repeat, inj_stop;
    logic [3:0]  wr_frame, inj_last, frame_idx;
    logic [2:0]  wr_slot;
    logic [13:0] wr_data;
    logic [13:0] c0, c1, c2, c3, c4, c5, c6, c7;
    logic        inj_valid, busy, done;
    logic [7:0]  pass_cnt;
    logic [13:0] dut_cl [8];

    int          n_checks = 0;
    int          n_errors = 0;
    logic [13:0] m_mem [16][8];
    int          m_pass;

    always #5 clk = ~clk;

    gem_cluster_injector dut (
        .i_clock(clk), .i_reset(reset),
        .i_wr_en(wr_en), .i_wr_frame(wr_frame), .i_wr_slot(wr_slot), .i_wr_data(wr_data),
        .i_clear(clear), .i_inj_start(inj_start), .i_inj_last(inj_last),
        .i_inj_repeat(inj_repeat), .i_inj_stop(inj_stop),
        .o_cluster0(c0), .o_cluster1(c1), .o_cluster2(c2), .o_cluster3(c3),
        .o_cluster4(c4), .o_cluster5(c5), .o_cluster6(c6), .o_cluster7(c7),
        .o_inj_valid(inj_valid), .o_frame_idx(frame_idx), .o_busy(busy),
        .o_done(done), .o_pass_cnt(pass_cnt)
    );

    assign dut_cl[0] = c0; assign dut_cl[1] = c1; assign dut_cl[2] = c2; assign dut_cl[3] = c3;
    assign dut_cl[4] = c4; assign dut_cl[5] = c5; assign dut_cl[6] = c6; assign dut_cl[7] = c7;

    typedef struct {
        logic        wr_en;
        logic [3:0]  wr_frame;
        logic [2:0]  wr_slot;
        logic [13:0] wr_data;
        logic        clear, start;
        logic [3:0]  last;
        logic        rep, stop;
        logic        e_valid;
        logic [3:0]  e_frame;
        logic        e_busy, e_done;
        logic [7:0]  e_pass;
        logic [7:0][13:0] e_cl;
    } vec_t;

    vec_t tv [12];

    function automatic vec_t mk(input logic we, input int wf, input int ws, input int wd,
                                input logic clr, input logic st, input int last,
                                input logic rep, input logic stp,
                                input logic ev, input int ef, input logic eb,
                                input logic ed, input int ep, input int cs, input int cv);
        vec_t v;
        v.wr_en = we; v.wr_frame = 4'(wf); v.wr_slot = 3'(ws); v.wr_data = 14'(wd);
        v.clear = clr; v.start = st; v.last = 4'(last); v.rep = rep; v.stop = stp;
        v.e_valid = ev; v.e_frame = 4'(ef); v.e_busy = eb; v.e_done = ed; v.e_pass = 8'(ep);
        for (int s = 0; s < 8; s++) v.e_cl[s] = BLANK;
        if (cs >= 0) v.e_cl[cs] = 14'(cv);
        return v;
    endfunction

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en = 0; wr_frame = 0; wr_slot = 0; wr_data = 0; clear = 0;
        inj_start = 0; inj_last = 0; inj_repeat = 0; inj_stop = 0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_status(input string tag, input logic ev, input int ef,
                              input logic eb, input logic ed, input int ep);
        chk({tag, ".inj_valid"}, 32'(inj_valid), 32'(ev));
        chk({tag, ".frame_idx"}, 32'(frame_idx), 32'(ef));
        chk({tag, ".busy"},      32'(busy),      32'(eb));
        chk({tag, ".done"},      32'(done),      32'(ed));
        chk({tag, ".pass_cnt"},  32'(pass_cnt),  32'(ep));
    endtask

    task automatic chk_frame(input string tag, input int f, input bit blank);
        for (int s = 0; s < 8; s++)
            chk($sformatf("%s.cluster%0d", tag, s), 32'(dut_cl[s]),
                32'(blank ? BLANK : m_mem[f][s]));
    endtask

    task automatic model_blank();
        for (int f = 0; f < 16; f++)
            for (int s = 0; s < 8; s++) m_mem[f][s] = BLANK;
    endtask

    // Observes the 16-cycle blanking sweep that follows reset release or clear acceptance
    task automatic wait_clear(input string tag);
        for (int i = 0; i < 16; i++) begin
            tick();
            chk($sformatf("%s.busy%0d", tag, i), 32'(busy), 32'(i != 15));
            chk($sformatf("%s.valid%0d", tag, i), 32'(inj_valid), 32'd0);
        end
        model_blank();
        $display("[%0t] clear sweep done (%s)", $time, tag);
    endtask

    task automatic do_write(input int f, input int s, input logic [13:0] d);
        wr_en = 1; wr_frame = 4'(f); wr_slot = 3'(s); wr_data = d;
        tick();
        idle_inputs();
        m_mem[f][s] = d;
        chk_status("write", 0, 0, 0, 0, m_pass);
        chk_frame("write", 0, 1);
        $display("[%0t] write frame=%0d slot=%0d data=%h", $time, f, s, d);
    endtask

    task automatic do_clear();
        clear = 1; inj_start = 1; inj_last = 3; wr_en = 1;
        wr_frame = 4'd2; wr_slot = 3'd1; wr_data = 14'h0ABC;
        tick();
        idle_inputs();
        chk_status("clear_accept", 0, 0, 1, 0, m_pass);
        wait_clear("clear");
    endtask

    // Expected output at play cycle k is frame k mod (last+1); passes done = k div (last+1)
    task automatic play(input int last, input bit rep, input int stop_at, input bit noise);
        int p0, k, f;
        bit fin;
        p0 = m_pass;
        inj_start = 1; inj_last = 4'(last); inj_repeat = rep;
        tick();
        idle_inputs();
        k = 0; fin = 0;
        while (!fin) begin
            f = k % (last + 1);
            chk_status($sformatf("play.k%0d", k), 1, f, 1, 0, sat(p0 + k / (last + 1)));
            chk_frame($sformatf("play.k%0d", k), f, 0);
            if (k == stop_at) begin
                inj_stop = 1;
                tick();
                idle_inputs();
                fin = 1;
            end else if (!rep && k == last) begin
                tick();
                fin = 1;
            end else begin
                if (noise) begin
                    wr_en = 1'($urandom); wr_frame = 4'($urandom); wr_slot = 3'($urandom);
                    wr_data = 14'($urandom); inj_start = 1'($urandom); clear = 1'($urandom);
                    inj_last = 4'($urandom); inj_repeat = 1'($urandom);
                end
                tick();
                idle_inputs();
                k++;
            end
        end
        m_pass = sat(p0 + (k + 1) / (last + 1));
        chk_status("play.end", 0, 0, 0, 1, m_pass);
        chk_frame("play.end", 0, 1);
        tick();
        chk("play.done_pulse", 32'(done), 32'd0);
        $display("[%0t] play last=%0d repeat=%0d stop_at=%0d cycles=%0d pass_cnt=%0d",
                 $time, last, rep, stop_at, k + 1, m_pass);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        reset = 1;
        repeat (3) tick();
        chk_status("reset", 0, 0, 1, 0, 0);
        chk_frame("reset", 0, 1);
        reset = 0;
        wait_clear("post_reset");
        m_pass = 0;

        // single blank frame pass, then done
        play(0, 0, -1, 0);

        tv[0]  = mk(1, 0, 0, 'h3805, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, -1, 0);
        tv[1]  = mk(1, 1, 3, 'h000D, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, -1, 0);
        tv[2]  = mk(0, 0, 0, 0,      0, 1, 1, 0, 0,  1, 0, 1, 0, 1,  0, 'h3805);
        tv[3]  = mk(0, 0, 0, 0,      0, 0, 0, 0, 0,  1, 1, 1, 0, 1,  3, 'h000D);
        tv[4]  = mk(0, 0, 0, 0,      0, 0, 0, 0, 0,  0, 0, 0, 1, 2, -1, 0);
        tv[5]  = mk(0, 0, 0, 0,      0, 0, 0, 0, 0,  0, 0, 0, 0, 2, -1, 0);
        tv[6]  = mk(0, 0, 0, 0,      0, 1, 1, 0, 0,  1, 0, 1, 0, 2,  0, 'h3805);
        tv[7]  = mk(1, 0, 0, 'h1234, 1, 1, 5, 1, 0,  1, 1, 1, 0, 2,  3, 'h000D);
        tv[8]  = mk(0, 0, 0, 0,      0, 0, 0, 0, 0,  0, 0, 0, 1, 3, -1, 0);
        tv[9]  = mk(0, 0, 0, 0,      0, 1, 1, 0, 0,  1, 0, 1, 0, 3,  0, 'h3805);
        tv[10] = mk(0, 0, 0, 0,      0, 0, 0, 0, 0,  1, 1, 1, 0, 3,  3, 'h000D);
        tv[11] = mk(0, 0, 0, 0,      0, 0, 0, 0, 0,  0, 0, 0, 1, 4, -1, 0);

        for (int i = 0; i < 12; i++) begin
            wr_en = tv[i].wr_en; wr_frame = tv[i].wr_frame; wr_slot = tv[i].wr_slot;
            wr_data = tv[i].wr_data; clear = tv[i].clear; inj_start = tv[i].start;
            inj_last = tv[i].last; inj_repeat = tv[i].rep; inj_stop = tv[i].stop;
            tick();
            idle_inputs();
            chk_status($sformatf("vec%0d", i), tv[i].e_valid, tv[i].e_frame,
                       tv[i].e_busy, tv[i].e_done, tv[i].e_pass);
            for (int s = 0; s < 8; s++)
                chk($sformatf("vec%0d.cluster%0d", i, s), 32'(dut_cl[s]), 32'(tv[i].e_cl[s]));
            $display("[%0t] vec%0d valid=%0d frame=%0d done=%0d pass=%0d c0=%h c3=%h",
                     $time, i, inj_valid, frame_idx, done, pass_cnt, c0, c3);
        end
        m_pass = 4;
        m_mem[0][0] = 14'h3805;
        m_mem[1][3] = 14'h000D;

        // clear beats start and write in the same idle cycle
        do_clear();

        // start beats a same-cycle write: the write must never land
        inj_start = 1; inj_last = 0; wr_en = 1; wr_frame = 0; wr_slot = 0; wr_data = 14'h1111;
        tick();
        idle_inputs();
        chk("prio.cluster0", 32'(c0), 32'(BLANK));
        chk("prio.valid", 32'(inj_valid), 32'd1);
        tick();
        chk("prio.done", 32'(done), 32'd1);
        m_pass = sat(m_pass + 1);
        tick();
        play(0, 0, -1, 0);

        for (int f = 0; f < 3; f++)
            for (int s = 0; s < 8; s++)
                if ($urandom_range(0, 1) == 1) do_write(f, s, 14'($urandom));

        // repeat over three frames, stopped on the last frame of the third pass
        play(2, 1, 8, 0);

        for (int op = 0; op < 120; op++) begin
            int r, last, stop_at;
            bit rep;
            r = $urandom_range(0, 9);
            if (r < 6) begin
                do_write($urandom_range(0, 15), $urandom_range(0, 7), 14'($urandom));
            end else if (r < 9) begin
                last = $urandom_range(0, 15);
                rep = 1'($urandom_range(0, 1));
                if (rep) stop_at = $urandom_range(0, 40);
                else stop_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, last) : -1;
                play(last, rep, stop_at, 1);
            end else begin
                do_clear();
            end
        end

        // pass counter saturation
        play(0, 1, 300, 1);
        chk("sat.pass_cnt", 32'(pass_cnt), 32'd255);

        // reset in the middle of playback
        inj_start = 1; inj_last = 9; inj_repeat = 0;
        tick();
        idle_inputs();
        repeat (5) tick();
        chk("midplay.frame_idx", 32'(frame_idx), 32'd5);
        reset = 1;
        tick();
        chk_status("midplay_reset", 0, 0, 1, 0, 0);
        chk_frame("midplay_reset", 0, 1);
        reset = 0;
        m_pass = 0;
        wait_clear("midplay_reset");
        play(1, 0, -1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
